// File: rtl/uart_mirror_fifo_if.sv
// Signal bundle between uart_mirror_fifo, the host logic and the UART_Rx/UART_Tx modules.
// master is the repeater's view; slave is the surrounding logic's view.
interface uart_mirror_fifo_if #(
    parameter int W = 8
) ();
    logic         validRx;
    logic         ackRx;
    logic [W-1:0] dataRx;
    logic         errRx;
    logic         busyTx;
    logic         sendTx;
    logic [W-1:0] dataTx;
    logic         errTx;
    logic         rxValid;
    logic         rxAck;
    logic [W-1:0] rxData;
    logic         rxErr;
    logic         txBusy;
    logic         txSend;
    logic [W-1:0] txData;
    logic         txErr;

    modport master (
        output validRx, input ackRx, output dataRx, output errRx,
        output busyTx, input sendTx, input dataTx, output errTx,
        input rxValid, output rxAck, input rxData, input rxErr,
        input txBusy, output txSend, output txData, input txErr
    );

    modport slave (
        input validRx, output ackRx, input dataRx, input errRx,
        input busyTx, output sendTx, output dataTx, input errTx,
        output rxValid, input rxAck, output rxData, output rxErr,
        output txBusy, input txSend, input txData, output txErr
    );
endinterface

// File: rtl/uart_mirror_fifo.sv
// Buffered UART repeater: Rx words are queued in a FIFO and retransmitted; passive bridge when disabled.
// Optional build macro UART_MIRROR_STATS_EN adds saturating statRx/statDrop/statTxErr counters.
module uart_mirror_fifo #(
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_FIFO_DEPTH      = 16
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            enable,
    input  logic                            ovfClr,
    uart_mirror_fifo_if.master              bus,
    output logic [$clog2(C_FIFO_DEPTH):0]   level,
    output logic                            ovf
`ifdef UART_MIRROR_STATS_EN
    ,
    output logic [15:0]                     statRx,
    output logic [15:0]                     statDrop,
    output logic [15:0]                     statTxErr
`endif
);
    localparam int AW      = $clog2(C_FIFO_DEPTH);
    localparam int C_LVL_W = AW + 1;
    localparam int W       = C_UART_DATA_WIDTH;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_WAIT = 2'd2} r_state_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_SEND = 2'd1, T_BUSY = 2'd2, T_DONE = 2'd3} t_state_t;

    r_state_t             r_state_q, r_state_d;
    t_state_t             t_state_q, t_state_d;
    logic [C_LVL_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_LVL_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                 ovf_q, ovf_d;
    logic                 rx_ack_q, rx_ack_d;
    logic                 tx_send_q, tx_send_d;
    logic [W-1:0]         tx_data_q, tx_data_d;
    logic [W-1:0]         mem_q [C_FIFO_DEPTH];

    logic                 push_req_s;
    logic                 push_ok_s;
    logic                 drop_ovf_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Rx state machine: capture one word per rxValid, always acknowledge.
    always_comb begin
        r_state_d  = r_state_q;
        push_req_s = 1'b0;
        if (!enable) begin
            r_state_d = R_IDLE;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (bus.rxValid) begin
                        r_state_d  = R_ACK;
                        push_req_s = ~bus.rxErr;
                    end else begin
                        r_state_d = R_IDLE;
                    end
                end
                R_ACK:  r_state_d = R_WAIT;
                R_WAIT: begin
                    if (!bus.rxValid) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
                default: r_state_d = R_IDLE;
            endcase
        end
        rx_ack_d = enable && (r_state_d == R_ACK);
    end

    // Tx state machine: pop the head word while Tx is idle, then follow txBusy.
    always_comb begin
        t_state_d = t_state_q;
        pop_s     = 1'b0;
        if (!enable) begin
            t_state_d = T_IDLE;
        end else begin
            case (t_state_q)
                T_IDLE: begin
                    if (!empty_s && !bus.txBusy) begin
                        t_state_d = T_SEND;
                        pop_s     = 1'b1;
                    end else begin
                        t_state_d = T_IDLE;
                    end
                end
                T_SEND: t_state_d = T_BUSY;
                T_BUSY: begin
                    if (bus.txBusy) begin
                        t_state_d = T_DONE;
                    end else begin
                        t_state_d = T_BUSY;
                    end
                end
                T_DONE: begin
                    if (!bus.txBusy) begin
                        t_state_d = T_IDLE;
                    end else begin
                        t_state_d = T_DONE;
                    end
                end
                default: t_state_d = T_IDLE;
            endcase
        end
        // send is launched from the T_SEND state register, so txData has a full cycle to settle
        tx_send_d = enable && (t_state_q == T_SEND);
    end

    // FIFO pointers, overflow flag and the held transmit word.
    always_comb begin
        push_ok_s  = push_req_s && (!full_s || pop_s);
        drop_ovf_s = push_req_s && full_s && !pop_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        if (!enable) begin
            wr_ptr_d = {C_LVL_W{1'b0}};
            rd_ptr_d = {C_LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + {{(C_LVL_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + {{(C_LVL_W-1){1'b0}}, 1'b1};
                tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
            end else begin
                rd_ptr_d  = rd_ptr_q;
                tx_data_d = tx_data_q;
            end
        end
        if (drop_ovf_s) begin
            ovf_d = 1'b1;
        end else if (ovfClr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state_q <= R_IDLE;
            t_state_q <= T_IDLE;
            wr_ptr_q  <= {C_LVL_W{1'b0}};
            rd_ptr_q  <= {C_LVL_W{1'b0}};
            ovf_q     <= 1'b0;
            rx_ack_q  <= 1'b0;
            tx_send_q <= 1'b0;
            tx_data_q <= {W{1'b0}};
        end else begin
            r_state_q <= r_state_d;
            t_state_q <= t_state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            rx_ack_q  <= rx_ack_d;
            tx_send_q <= tx_send_d;
            tx_data_q <= tx_data_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.rxData;
        end
    end

`ifdef UART_MIRROR_STATS_EN
    logic [15:0] stat_rx_q, stat_rx_d;
    logic [15:0] stat_drop_q, stat_drop_d;
    logic [15:0] stat_tx_err_q, stat_tx_err_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        if (inc && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    // Statistics counters; ovfClr clears them along with the overflow flag.
    always_comb begin
        if (ovfClr) begin
            stat_rx_d     = 16'd0;
            stat_drop_d   = 16'd0;
            stat_tx_err_d = 16'd0;
        end else begin
            stat_rx_d     = sat_inc(stat_rx_q, push_ok_s);
            stat_drop_d   = sat_inc(stat_drop_q,
                                    drop_ovf_s || (enable && (r_state_q == R_IDLE) &&
                                                   bus.rxValid && bus.rxErr));
            stat_tx_err_d = sat_inc(stat_tx_err_q, enable && bus.txErr);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            stat_rx_q     <= 16'd0;
            stat_drop_q   <= 16'd0;
            stat_tx_err_q <= 16'd0;
        end else begin
            stat_rx_q     <= stat_rx_d;
            stat_drop_q   <= stat_drop_d;
            stat_tx_err_q <= stat_tx_err_d;
        end
    end

    assign statRx    = stat_rx_q;
    assign statDrop  = stat_drop_q;
    assign statTxErr = stat_tx_err_q;
`endif

    // Mirror mode drives Tx from the FIFO and hides Tx from the host; passive mode bridges.
    assign bus.validRx = bus.rxValid;
    assign bus.dataRx  = bus.rxData;
    assign bus.errRx   = bus.rxErr;
    assign bus.rxAck   = enable ? rx_ack_q  : bus.ackRx;
    assign bus.txSend  = enable ? tx_send_q : bus.sendTx;
    assign bus.txData  = enable ? tx_data_q : bus.dataTx;
    assign bus.busyTx  = enable ? 1'b1      : bus.txBusy;
    assign bus.errTx   = enable ? 1'b0      : bus.txErr;

    assign level = wr_ptr_q - rd_ptr_q;
    assign ovf   = ovf_q;
endmodule
